// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_if
//  Purpose  : Request/response bus from the pipeline plus the word-wide data
//             port towards the unified memory block (AddressB/WriteData/
//             EnableWriteB/ReadDataB).
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // Access unit side: accepts requests, drives the memory port
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    // Pipeline/memory side
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Single-outstanding load/store initiator for the data port of the
//             unified memory. Handles byte/half/word accesses, sign/zero
//             extension on loads and read-modify-write for sub-word RAM stores.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int          READ_LATENCY = 1,       // legal 1..4
    parameter logic [15:0] MMIO_TAG     = 16'hFFFF
) (
    input  wire logic clk,
    input  wire logic reset,
    mem_access_unit_if.slave bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READ  = 3'd1;
    localparam logic [2:0] c_MERGE = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_RESP  = 3'd4;

    localparam logic [1:0] c_LAST_RD = 2'(READ_LATENCY - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        uns_q;
    logic        err_q;
    logic [1:0]  cnt_q;
    logic [31:0] word_q;    // outgoing store word (lane-placed or merged)
    logic [31:0] rdata_q;   // response data, held between responses

    // Right-justified store data moved to its byte lane, other lanes zero
    function automatic logic [31:0] f_place(input logic [31:0] d, input logic [1:0] size,
                                            input logic [1:0] lane);
        case (size)
            2'b00:   f_place = {24'd0, d[7:0]} << {lane, 3'b000};
            2'b01:   f_place = {16'd0, d[15:0]} << {lane[1], 4'b0000};
            default: f_place = d;
        endcase
    endfunction

    // Lanes written by a store of the given size
    function automatic logic [31:0] f_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   f_mask = 32'h0000_00FF << {lane, 3'b000};
            2'b01:   f_mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            default: f_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Lane extraction plus sign/zero extension for loads
    function automatic logic [31:0] f_extend(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   f_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   f_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: f_extend = w;
        endcase
    endfunction

    logic w_err_in;
    logic w_mmio_in;
    logic w_direct_wr;
    logic w_read_done;
    logic [31:0] w_mask;

    assign w_err_in    = (bus.req_size == 2'b11) ||
                         ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign w_mmio_in   = (bus.req_addr[31:16] == MMIO_TAG);
    // Word stores and all MMIO stores skip the read half of read-modify-write
    assign w_direct_wr = bus.req_write && ((bus.req_size == 2'b10) || w_mmio_in);
    assign w_read_done = (state_q == c_READ) && (cnt_q == c_LAST_RD);
    assign w_mask      = f_mask(size_q, addr_q[1:0]);

    // State register; reset aborts any operation immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= c_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (bus.req_valid) begin
                    if (w_err_in)         state_d = c_RESP;
                    else if (w_direct_wr) state_d = c_WRITE;
                    else                  state_d = c_READ;
                end
            end
            c_READ:  if (w_read_done) state_d = write_q ? c_MERGE : c_RESP;
            c_MERGE: state_d = c_WRITE;
            c_WRITE: state_d = c_IDLE;
            c_RESP:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Request capture, read sampling, merge and response data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        size_q  <= bus.req_size;
                        write_q <= bus.req_write;
                        uns_q   <= bus.req_unsigned;
                        err_q   <= w_err_in;
                        cnt_q   <= '0;
                        word_q  <= f_place(bus.req_wdata, bus.req_size, bus.req_addr[1:0]);
                        // Stores and errors report zero data in their response cycle
                        if (w_err_in || w_direct_wr) rdata_q <= '0;
                    end
                end
                c_READ: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (w_read_done) begin
                        if (write_q) word_q  <= bus.mem_rdata;
                        else         rdata_q <= f_extend(bus.mem_rdata, size_q, addr_q[1:0], uns_q);
                    end
                end
                c_MERGE: begin
                    word_q  <= (word_q & ~w_mask) | (f_place(wdata_q, size_q, addr_q[1:0]) & w_mask);
                    rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output decode from state
    always_comb begin
        bus.req_ready  = (state_q == c_IDLE);
        bus.resp_valid = (state_q == c_RESP) || (state_q == c_WRITE);
        bus.resp_err   = (state_q == c_RESP) && err_q;
        bus.resp_rdata = rdata_q;
        bus.mem_we     = (state_q == c_WRITE);
        bus.mem_addr   = (state_q == c_IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
        bus.mem_wdata  = (state_q == c_WRITE) ? word_q : 32'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Directed self-checking bench for mem_access_unit with a small
//             word-addressed RAM and an MMIO write recorder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit #(.READ_LATENCY(1), .MMIO_TAG(16'hFFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: combinational read (one-cycle read latency seen by the unit)
    logic        preload;
    logic [31:0] ram [0:255];
    logic [31:0] mmio_waddr, mmio_wdata;
    int          mmio_writes;

    assign bus.mem_rdata = ram[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (preload) begin
            ram[64]     <= 32'h8899AABB;
            ram[65]     <= 32'h0;
            mmio_writes <= 0;
            mmio_waddr  <= 32'h0;
            mmio_wdata  <= 32'h0;
        end else if (bus.mem_we) begin
            if (bus.mem_addr[31:16] == 16'hFFFF) begin
                mmio_writes <= mmio_writes + 1;
                mmio_waddr  <= bus.mem_addr;
                mmio_wdata  <= bus.mem_wdata;
            end else begin
                ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the most recent request (cycle k = k-th cycle after acceptance)
    int          r_cyc, r_we_n, r_we_cyc;
    logic [31:0] r_data, r_we_data;
    logic        r_err;

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        r_cyc = -1; r_we_n = 0; r_we_cyc = -1; r_we_data = 32'h0; r_data = 32'h0; r_err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                r_we_n++; r_we_cyc = k; r_we_data = bus.mem_wdata;
            end
            if (bus.resp_valid) begin
                r_cyc = k; r_data = bus.resp_rdata; r_err = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        preload = 1'b1;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b expected 0", bus.resp_err); end
        n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h expected 0", bus.resp_rdata); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
        reset   = 1'b0;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic test_loads();
        string       nm [7] = '{"lb_101", "lbu_101", "lh_102", "lhu_102", "lw_100", "lb_103", "lbu_100"};
        logic [1:0]  sz [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
        logic        un [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ad [7] = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h100, 32'h103, 32'h100};
        logic [31:0] ex [7] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                                32'h8899AABB, 32'hFFFFFF88, 32'h000000BB};
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0);
            n_checks++; if (r_cyc != 2) begin n_fail++; $display("FAIL %s_latency: got %0d expected 2", nm[i], r_cyc); end
            n_checks++; if (r_data !== ex[i]) begin n_fail++; $display("FAIL %s_data: got %h expected %h", nm[i], r_data, ex[i]); end
            n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL %s_err: got %b expected 0", nm[i], r_err); end
            n_checks++; if (r_we_n != 0) begin n_fail++; $display("FAIL %s_no_write: got %0d writes expected 0", nm[i], r_we_n); end
        end
    endtask

    task automatic test_subword_store();
        // sb 0x102 : RMW, write only in cycle 3; upper wdata bits must be discarded
        do_req(1'b1, 2'd0, 1'b0, 32'h102, 32'hFFFFFF5A);
        n_checks++; if (r_we_n != 1) begin n_fail++; $display("FAIL sb_we_count: got %0d expected 1", r_we_n); end
        n_checks++; if (r_we_cyc != 3) begin n_fail++; $display("FAIL sb_we_cycle: got %0d expected 3", r_we_cyc); end
        n_checks++; if (r_we_data !== 32'h885AAABB) begin n_fail++; $display("FAIL sb_wdata: got %h expected 885aaabb", r_we_data); end
        n_checks++; if (r_cyc != 3) begin n_fail++; $display("FAIL sb_resp_cycle: got %0d expected 3", r_cyc); end
        n_checks++; if (r_data !== 32'h0) begin n_fail++; $display("FAIL sb_resp_rdata: got %h expected 0", r_data); end
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        n_checks++; if (r_data !== 32'h885AAABB) begin n_fail++; $display("FAIL sb_readback: got %h expected 885aaabb", r_data); end
        // sh 0x100 : lower half replaced
        do_req(1'b1, 2'd1, 1'b0, 32'h100, 32'hABCD1234);
        n_checks++; if (r_we_data !== 32'h885A1234) begin n_fail++; $display("FAIL sh_wdata: got %h expected 885a1234", r_we_data); end
        n_checks++; if (r_we_cyc != 3 || r_we_n != 1) begin n_fail++; $display("FAIL sh_we_timing: got cycle %0d count %0d expected cycle 3 count 1", r_we_cyc, r_we_n); end
        do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
        n_checks++; if (r_data !== 32'hFFFF885A) begin n_fail++; $display("FAIL sh_readback_hi: got %h expected ffff885a", r_data); end
    endtask

    task automatic test_errors();
        string       nm [3] = '{"sh_101", "lw_102", "size11"};
        logic        wr [3] = '{1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
        logic [31:0] ad [3] = '{32'h101, 32'h102, 32'h100};
        for (int i = 0; i < 3; i++) begin
            do_req(wr[i], sz[i], 1'b0, ad[i], 32'h12345678);
            n_checks++; if (r_cyc != 1) begin n_fail++; $display("FAIL %s_resp_cycle: got %0d expected 1", nm[i], r_cyc); end
            n_checks++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL %s_err: got %b expected 1", nm[i], r_err); end
            n_checks++; if (r_data !== 32'h0) begin n_fail++; $display("FAIL %s_rdata: got %h expected 0", nm[i], r_data); end
            n_checks++; if (r_we_n != 0) begin n_fail++; $display("FAIL %s_no_write: got %0d expected 0", nm[i], r_we_n); end
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        n_checks++; if (r_data !== 32'h885A1234) begin n_fail++; $display("FAIL err_ram_intact: got %h expected 885a1234", r_data); end
    endtask

    task automatic test_mmio_store();
        do_req(1'b1, 2'd0, 1'b0, 32'hFFFF0005, 32'h0000003C);
        n_checks++; if (r_cyc != 1) begin n_fail++; $display("FAIL mmio_sb_resp_cycle: got %0d expected 1", r_cyc); end
        n_checks++; if (r_we_cyc != 1 || r_we_n != 1) begin n_fail++; $display("FAIL mmio_sb_we: got cycle %0d count %0d expected cycle 1 count 1", r_we_cyc, r_we_n); end
        n_checks++; if (r_we_data !== 32'h00003C00) begin n_fail++; $display("FAIL mmio_sb_wdata: got %h expected 00003c00", r_we_data); end
        n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL mmio_sb_err: got %b expected 0", r_err); end
        @(negedge clk);
        n_checks++; if (mmio_writes != 1) begin n_fail++; $display("FAIL mmio_sb_count: got %0d expected 1", mmio_writes); end
        n_checks++; if (mmio_waddr !== 32'hFFFF0004) begin n_fail++; $display("FAIL mmio_sb_addr: got %h expected ffff0004", mmio_waddr); end
        do_req(1'b1, 2'd1, 1'b0, 32'hFFFF0002, 32'h00001234);
        n_checks++; if (r_we_data !== 32'h12340000 || r_we_cyc != 1) begin n_fail++; $display("FAIL mmio_sh: got data %h cycle %0d expected 12340000 cycle 1", r_we_data, r_we_cyc); end
    endtask

    task automatic test_word_store();
        do_req(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF);
        n_checks++; if (r_we_cyc != 1 || r_cyc != 1) begin n_fail++; $display("FAIL sw_timing: got we cycle %0d resp cycle %0d expected 1 and 1", r_we_cyc, r_cyc); end
        n_checks++; if (r_we_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h expected deadbeef", r_we_data); end
        do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        n_checks++; if (r_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_readback: got %h expected deadbeef", r_data); end
    endtask

    task automatic test_back_to_back();
        do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
        n_checks++; if (r_data !== 32'h00000012) begin n_fail++; $display("FAIL b2b_first: got %h expected 00000012", r_data); end
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_resp: got %b expected 0", bus.req_ready); end
        do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
        n_checks++; if (r_cyc != 2 || r_data !== 32'h0000885A) begin n_fail++; $display("FAIL b2b_second: got cycle %0d data %h expected cycle 2 data 0000885a", r_cyc, r_data); end
    endtask

    task automatic test_reset_abort();
        int we_seen, resp_seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h100; bus.req_wdata = 32'h77;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_addr !== 32'h100 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_read: got addr %h ready %b expected 00000100 0", bus.mem_addr, bus.req_ready); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.mem_we !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_async: got we %b ready %b expected 0 1", bus.mem_we, bus.req_ready); end
        @(negedge clk);
        reset = 1'b0;
        we_seen = 0; resp_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.mem_we) we_seen++;
            if (bus.resp_valid) resp_seen++;
        end
        n_checks++; if (we_seen != 0 || resp_seen != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d writes %0d responses expected 0 0", we_seen, resp_seen); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", bus.req_ready); end
        n_checks++; if (ram[64] !== 32'h885A1234) begin n_fail++; $display("FAIL abort_ram: got %h expected 885a1234", ram[64]); end
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        n_checks++; if (r_cyc != 2 || r_data !== 32'h885A1234) begin n_fail++; $display("FAIL abort_recover: got cycle %0d data %h expected cycle 2 data 885a1234", r_cyc, r_data); end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        test_reset();
        test_loads();
        test_subword_store();
        test_errors();
        test_mmio_store();
        test_word_store();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
